sc_period_meter: RTL
====================

// Module: sc_period_meter
// PURPOSE
//  Receive side of the programmable tick generator (SC_COUNTER).
//  Watches its active-low tick stream and measures the clock-cycle distance between consecutive ticks.
//  Publishes the last period, a one-cycle valid strobe, a match flag against an expected period, and a sticky overflow flag.
//  Sits on the same 50 MHz clock domain as the generator. Used for closed-loop self-check of loaded limits.
// PARAMETERS
//  METER_DATAWIDTH  8  width of cycle counter, period and expected buses
// PORTS
//  SC_COUNTER_CLOCK_50        in   1  system clock, rising edge
//  SC_COUNTER_RESET_InHigh    in   1  asynchronous, active-high reset
//  SC_METER_tick_InLow        in   1  tick from generator, active low, synchronous to clock
//  SC_METER_clear_InLow       in   1  synchronous clear/re-arm, active low
//  SC_METER_expected_InBUS    in   W  expected period in cycles, used for match compare
//  SC_METER_period_OutBUS     out  W  last measured period (cycles), registered
//  SC_METER_valid_OutHigh     out  1  one-cycle strobe: period/match just updated
//  SC_METER_match_OutHigh     out  1  level: last period == expected sampled at that update
//  SC_METER_overflow_OutHigh  out  1  sticky: counter saturated since last clear
//  SC_METER_armed_OutHigh     out  1  high in MEASURE state
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, tick_d=1, period=0, valid=0, match=0, overflow=0, armed=0.
//  Tick event:
//   - event = (tick==0) && (tick_d==1), where tick_d is the previous-cycle sample.
//   - A low held for several cycles counts as one event. Minimum measurable period = 2.
//  FSM states:
//   - IDLE: waits for first event. On event -> MEASURE, cnt<=1. No valid strobe.
//   - MEASURE, no event: cnt<=cnt+1, saturating at 2^W-1. Reaching 2^W-1 sets overflow<=1 (sticky).
//   - MEASURE, event:
//     - period<=cnt; match<=(cnt==expected); valid<=1 for exactly one cycle.
//     - cnt<=1; stay in MEASURE.
//  Period definition: events at cycles t0,t1 give period = t1-t0. A saturated count reports 2^W-1.
//  Latency: period/match/valid visible in the cycle after the event edge. Between events, period and match hold.
//  valid: deasserts the cycle after it asserts unless another event occurs; back-to-back strobes are impossible (min period 2).
//  expected changing mid-period: only the value sampled at the event cycle matters.
//  clear low (synchronous):
//   - Priority over event and over saturation.
//   - state<=IDLE, cnt<=0, period<=0, match<=0, valid<=0, overflow<=0.
//   - tick_d still samples the tick, so a low held across clear release is NOT a new event.
//  Reset mid-measurement: all state returns to reset values immediately. First post-reset event only arms.
//  armed = (state==MEASURE), registered.
// TESTING
//  1. Reset, expected=5, tick low 1 cycle every 5 cycles ->
//     - first tick only arms;
//     - each later tick: valid 1 cycle, period=5, match=1.
//  2. Same stream, expected=6 -> period=5, match=0 on every strobe; overflow stays 0.
//  3. Tick held low 3 cycles, repeated every 10 cycles -> period=10, one valid per tick.
//  4. Arm, then no tick for 300 cycles (W=8), then a tick ->
//     - overflow=1 from cycle 255 onward;
//     - strobe reports period=255; overflow stays 1 until clear.
//  5. Clear pulsed low 1 cycle while tick stream runs ->
//     - period=0, match=0, overflow=0, armed=0;
//     - next tick re-arms; the tick after it reports the correct period.
//  6. Assert reset mid-period, release, ticks every 7 cycles ->
//     - outputs 0 during reset;
//     - first strobe arrives at the second post-reset tick with period=7.

Source files
------------

// File: rtl/sc_period_meter.sv
// Period meter for the SC_COUNTER tick stream: measures clock cycles between
// falling-edge tick events and publishes period, match, overflow and armed status.
module sc_period_meter #(
    parameter int unsigned METER_DATAWIDTH = 8
) (
    input  logic                       SC_COUNTER_CLOCK_50,
    input  logic                       SC_COUNTER_RESET_InHigh,
    input  logic                       SC_METER_tick_InLow,
    input  logic                       SC_METER_clear_InLow,
    input  logic [METER_DATAWIDTH-1:0] SC_METER_expected_InBUS,
    output logic [METER_DATAWIDTH-1:0] SC_METER_period_OutBUS,
    output logic                       SC_METER_valid_OutHigh,
    output logic                       SC_METER_match_OutHigh,
    output logic                       SC_METER_overflow_OutHigh,
    output logic                       SC_METER_armed_OutHigh
);

    localparam logic [METER_DATAWIDTH-1:0] CntMax  = '1;
    localparam logic [METER_DATAWIDTH-1:0] CntOne  = {{(METER_DATAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [METER_DATAWIDTH-1:0] CntZero = '0;

    typedef enum logic {
        StIdle,
        StMeasure
    } t_state;

    t_state                     r_state;
    logic [METER_DATAWIDTH-1:0] r_cnt;
    logic                       r_tick_d;
    logic [METER_DATAWIDTH-1:0] r_period;
    logic                       r_valid;
    logic                       r_match;
    logic                       r_overflow;
    logic                       r_armed;

    logic                       w_event;
    logic [METER_DATAWIDTH-1:0] w_cnt_inc;

    // A low level held for several cycles yields a single event on its leading edge.
    assign w_event   = ~SC_METER_tick_InLow & r_tick_d;
    assign w_cnt_inc = r_cnt + CntOne;

    always_ff @(posedge SC_COUNTER_CLOCK_50 or posedge SC_COUNTER_RESET_InHigh) begin
        if (SC_COUNTER_RESET_InHigh) begin
            r_state    <= StIdle;
            r_cnt      <= CntZero;
            r_tick_d   <= 1'b1;
            r_period   <= CntZero;
            r_valid    <= 1'b0;
            r_match    <= 1'b0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            // The edge detector keeps sampling through clear, so a low held
            // across clear release is not seen as a fresh event.
            r_tick_d <= SC_METER_tick_InLow;
            r_valid  <= 1'b0;
            if (!SC_METER_clear_InLow) begin
                r_state    <= StIdle;
                r_cnt      <= CntZero;
                r_period   <= CntZero;
                r_match    <= 1'b0;
                r_overflow <= 1'b0;
                r_armed    <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_event) begin
                            r_state <= StMeasure;
                            r_cnt   <= CntOne;
                            r_armed <= 1'b1;
                        end
                    end
                    StMeasure: begin
                        if (w_event) begin
                            r_period <= r_cnt;
                            r_match  <= (r_cnt == SC_METER_expected_InBUS);
                            r_valid  <= 1'b1;
                            r_cnt    <= CntOne;
                        end else if (r_cnt != CntMax) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CntMax) begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_cnt   <= CntZero;
                        r_armed <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SC_METER_period_OutBUS    = r_period;
    assign SC_METER_valid_OutHigh    = r_valid;
    assign SC_METER_match_OutHigh    = r_match;
    assign SC_METER_overflow_OutHigh = r_overflow;
    assign SC_METER_armed_OutHigh    = r_armed;

endmodule
